spram_rr_arbiter: RTL and testbench



---
 rtl/spram_rr_arbiter_pkg.sv | 10 +
 rtl/spram_rr_arbiter_ram.sv | 18 +
 rtl/spram_rr_arbiter.sv | 97 +++++++++
 tb/tb_spram_rr_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/spram_rr_arbiter_pkg.sv
// Shared defaults and encodings for the round-robin single-port RAM arbiter.
package spram_rr_arbiter_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 3;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/spram_rr_arbiter_ram.sv
// Single-port RAM hard block model: synchronous write, registered read-first output.
module single_port_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] mem [2**DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
    out <= mem[addr];
  end
endmodule

// File: rtl/spram_rr_arbiter.sv
// Two-client round-robin arbiter sharing one single-port RAM; zero-sweeps the RAM after reset.
module spram_rr_arbiter
  import spram_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [DEPTH-1:0] addr_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  output logic             rvalid_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [DEPTH-1:0] addr_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             rvalid_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             init_done
);
  localparam logic [DEPTH:0] INIT_LAST = {1'b0, {DEPTH{1'b1}}};

  state_e           state, state_next;
  logic [DEPTH:0]   init_cnt;
  logic             prio;
  logic             ram_we;
  logic [DEPTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_data;
  logic [WIDTH-1:0] ram_out;

  // Grants are suppressed while reset is high so no access lands on the reset edge.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == ST_RUN && !reset) begin
      if (req_a && (!req_b || prio == SEL_A)) gnt_a = 1'b1;
      else if (req_b)                         gnt_b = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_cnt == INIT_LAST) state_next = ST_RUN;
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (state == ST_INIT) begin
      ram_we   = 1'b1;
      ram_addr = init_cnt[DEPTH-1:0];
    end else if (gnt_a) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_data = data_a;
    end else if (gnt_b) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_data = data_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      prio     <= SEL_A;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      state    <= state_next;
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (gnt_a)      prio <= SEL_B;
      else if (gnt_b) prio <= SEL_A;
    end
  end

  single_port_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ram0 (
    .clk  (clock),
    .we   (ram_we),
    .addr (ram_addr),
    .data (ram_data),
    .out  (ram_out)
  );

  assign init_done = (state == ST_RUN);
  assign rdata_a   = rvalid_a ? ram_out : '0;
  assign rdata_b   = rvalid_b ? ram_out : '0;
endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed + random bench for spram_rr_arbiter against a queue-free behavioural memory model.
module tb_spram_rr_arbiter;
  logic       clock, reset;
  logic       req_a, we_a, gnt_a, rvalid_a;
  logic [2:0] addr_a;
  logic [7:0] data_a, rdata_a;
  logic       req_b, we_b, gnt_b, rvalid_b;
  logic [2:0] addr_b;
  logic [7:0] data_b, rdata_b;
  logic       init_done;

  spram_rr_arbiter #(.WIDTH(8), .DEPTH(3)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .init_done(init_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: memory array, sweep progress, who was served last, pending read results.
  logic [7:0] m_mem [8];
  bit         m_init   = 1'b1;
  int         m_cnt    = 0;
  bit         m_last_a = 1'b0;
  bit         m_pa, m_pb;
  logic [7:0] m_da, m_db;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic ra, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                      input logic rb, input logic wb, input logic [2:0] ab, input logic [7:0] db);
    bit ega, egb;
    @(negedge clock);
    reset = rst;
    req_a = ra; we_a = wa; addr_a = aa; data_a = da;
    req_b = rb; we_b = wb; addr_b = ab; data_b = db;
    ega = 1'b0;
    egb = 1'b0;
    if (!rst && !m_init) begin
      if (ra && (!rb || !m_last_a)) ega = 1'b1;
      else if (rb)                  egb = 1'b1;
    end
    #2;
    if (chk_en) begin
      chk("gnt_a", gnt_a, ega);
      chk("gnt_b", gnt_b, egb);
      chk("rvalid_a", rvalid_a, m_pa);
      chk("rvalid_b", rvalid_b, m_pb);
      chk("rdata_a", rdata_a, m_pa ? m_da : 8'h00);
      chk("rdata_b", rdata_b, m_pb ? m_db : 8'h00);
      chk("init_done", init_done, !m_init);
    end
    @(posedge clock);
    if (rst) begin
      m_init = 1'b1; m_cnt = 0; m_pa = 1'b0; m_pb = 1'b0; m_last_a = 1'b0;
    end else if (m_init) begin
      m_mem[m_cnt] = 8'h00;
      m_cnt++;
      if (m_cnt == 8) m_init = 1'b0;
      m_pa = 1'b0; m_pb = 1'b0;
    end else begin
      m_pa = ega && !wa; m_da = m_mem[aa];
      m_pb = egb && !wb; m_db = m_mem[ab];
      if (ega && wa) m_mem[aa] = da;
      if (egb && wb) m_mem[ab] = db;
      if (ega)      m_last_a = 1'b1;
      else if (egb) m_last_a = 1'b0;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; data_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; data_b = '0;

    // Reset, then sweep: init_done rises exactly on the 8th edge after reset low.
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 7; i++) idle();
    #1 chk("init_done_edge7", init_done, 1'b0);
    idle();
    #1 chk("init_done_edge8", init_done, 1'b1);

    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 3'(i), 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    idle();

    // A writes 0x5A to addr 3, B reads it back.
    step(1'b0, 1'b1, 1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00);
    #1 chk("rdata_b_5a", rdata_b, 8'h5A);
    chk("rvalid_a_quiet", rvalid_a, 1'b0);
    idle();

    // Both requesting: strict alternation.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00);
    idle();

    // Request held through the sweep is served on the first RUN cycle.
    step(1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    #1 chk("held_req_rvalid", rvalid_a, 1'b1);
    chk("held_req_rdata", rdata_a, 8'h00);
    idle();

    // Write-then-read 0xFF at addr 7, reset mid-read, contents lost.
    step(1'b0, 1'b1, 1'b1, 3'd7, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    #1 chk("raw_rdata_ff", rdata_a, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    #1 chk("reset_drops_rvalid", rvalid_a, 1'b0);
    for (int i = 0; i < 8; i++) idle();
    step(1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    #1 chk("after_reset_addr7", rdata_a, 8'h00);
    idle();

    // B alone back-to-back writes, then a lone A request.
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h11);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h22);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd2, 8'h33);
    step(1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    #1 chk("b_write_readback", rdata_a, 8'h22);
    idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
